// File: rtl/llbit_resv_table_pkg.sv
// Shared constants, width helpers and the per-thread reservation bundle
// for the LL/SC reservation tracker.
package llbit_resv_table_pkg;

    localparam int LLBIT_LINE_OFFSET    = 4;
    localparam int LLBIT_ADDR_WIDTH     = 32;
    localparam int LLBIT_TIMEOUT_CYCLES = 1023;

    // Thread-id width; a single thread still gets a 1-bit id port.
    function automatic int tid_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_width(input int t);
        return (t > 0) ? $clog2(t + 1) : 1;
    endfunction

    localparam int LLBIT_TAG_WIDTH = LLBIT_ADDR_WIDTH - LLBIT_LINE_OFFSET;
    localparam int LLBIT_CNT_WIDTH = $clog2(LLBIT_TIMEOUT_CYCLES + 1);

    typedef struct packed {
        logic                       valid;
        logic [LLBIT_TAG_WIDTH-1:0] tag;
        logic [LLBIT_CNT_WIDTH-1:0] cnt;
    } resv_entry_t;

endpackage

// File: rtl/llbit_resv_table_entry.sv
// Single-thread reservation: IDLE/HELD valid bit, line tag and an optional
// timeout down-counter.
module llbit_resv_entry
    import llbit_resv_table_pkg::*;
#(
    parameter int TAG_W          = LLBIT_TAG_WIDTH,
    parameter int TIMEOUT_CYCLES = LLBIT_TIMEOUT_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             ll_hit,
    input  logic [TAG_W-1:0] ll_tag,
    input  logic             sc_hit,
    input  logic             snoop_valid,
    input  logic [TAG_W-1:0] snoop_tag,
    output logic             valid_o,
    output logic [TAG_W-1:0] tag_o
);

    localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);

    logic             valid_q, valid_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             expire;

    generate
        if (TIMEOUT_CYCLES != 0) begin : g_timer
            logic [CNT_W-1:0] cnt_q, cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (ll_hit && !flush) begin
                    cnt_d = CNT_W'(TIMEOUT_CYCLES);
                end else if (valid_q && cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign expire = valid_q && (cnt_q == CNT_W'(1));
        end else begin : g_no_timer
            assign expire = 1'b0;
        end
    endgenerate

    // Priority: flush, LL (re-arm), SC consume, snoop hit, timeout.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (ll_hit) begin
            valid_d = 1'b1;
            tag_d   = ll_tag;
        end else if (sc_hit) begin
            valid_d = 1'b0;
        end else if (snoop_valid && valid_q && (snoop_tag == tag_q)) begin
            valid_d = 1'b0;
        end else if (expire) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
        end
    end

    assign valid_o = valid_q;
    assign tag_o   = tag_q;

endmodule

// File: rtl/llbit_resv_table.sv
// Multi-thread LL/SC reservation table: per-thread entries, SC verdict mux
// and a one-cycle registered verdict.
module llbit_resv_table
    import llbit_resv_table_pkg::*;
#(
    parameter int NUM_THREADS    = 2,
    parameter int ADDR_WIDTH     = LLBIT_ADDR_WIDTH,
    parameter int LINE_OFFSET    = LLBIT_LINE_OFFSET,
    parameter int TIMEOUT_CYCLES = LLBIT_TIMEOUT_CYCLES
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                ll_valid,
    input  logic [tid_width(NUM_THREADS)-1:0]   ll_tid,
    input  logic [ADDR_WIDTH-1:0]               ll_addr,
    input  logic                                sc_valid,
    input  logic [tid_width(NUM_THREADS)-1:0]   sc_tid,
    input  logic [ADDR_WIDTH-1:0]               sc_addr,
    input  logic                                snoop_valid,
    input  logic [ADDR_WIDTH-1:0]               snoop_addr,
    input  logic [NUM_THREADS-1:0]              flush,
    output logic                                sc_resp_valid,
    output logic                                sc_resp_success,
    output logic [NUM_THREADS-1:0]              llbit_o
);

    localparam int TID_W = tid_width(NUM_THREADS);
    localparam int TAG_W = ADDR_WIDTH - LINE_OFFSET;

    logic [TAG_W-1:0]       ll_tag, sc_tag, snoop_tag;
    logic [NUM_THREADS-1:0] valid_vec;
    logic [TAG_W-1:0]       tag_arr [NUM_THREADS];

    assign ll_tag    = ll_addr[ADDR_WIDTH-1:LINE_OFFSET];
    assign sc_tag    = sc_addr[ADDR_WIDTH-1:LINE_OFFSET];
    assign snoop_tag = snoop_addr[ADDR_WIDTH-1:LINE_OFFSET];

    logic unused_offset_bits;
    assign unused_offset_bits = ^{ll_addr[LINE_OFFSET-1:0], sc_addr[LINE_OFFSET-1:0],
                                  snoop_addr[LINE_OFFSET-1:0]};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_THREADS; gi++) begin : g_entry
            logic ll_hit, sc_hit;
            assign ll_hit = ll_valid && (ll_tid == TID_W'(gi));
            assign sc_hit = sc_valid && (sc_tid == TID_W'(gi));

            llbit_resv_entry #(
                .TAG_W          (TAG_W),
                .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
            ) u_entry (
                .clk         (clk),
                .rst         (rst),
                .flush       (flush[gi]),
                .ll_hit      (ll_hit),
                .ll_tag      (ll_tag),
                .sc_hit      (sc_hit),
                .snoop_valid (snoop_valid),
                .snoop_tag   (snoop_tag),
                .valid_o     (valid_vec[gi]),
                .tag_o       (tag_arr[gi])
            );
        end
    endgenerate

    // An out-of-range sc_tid selects nothing, so its verdict is failure.
    logic             sel_valid, sel_flush;
    logic [TAG_W-1:0] sel_tag;

    always_comb begin
        sel_valid = 1'b0;
        sel_flush = 1'b0;
        sel_tag   = '0;
        for (int t = 0; t < NUM_THREADS; t++) begin
            if (sc_tid == TID_W'(t)) begin
                sel_valid = valid_vec[t];
                sel_flush = flush[t];
                sel_tag   = tag_arr[t];
            end
        end
    end

    logic resp_valid_q, resp_valid_d;
    logic resp_success_q, resp_success_d;

    always_comb begin
        resp_valid_d   = sc_valid;
        resp_success_d = sc_valid && sel_valid && (sc_tag == sel_tag) && !sel_flush
                         && !(snoop_valid && (snoop_tag == sel_tag));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_valid_q   <= 1'b0;
            resp_success_q <= 1'b0;
        end else begin
            resp_valid_q   <= resp_valid_d;
            resp_success_q <= resp_success_d;
        end
    end

    assign sc_resp_valid   = resp_valid_q;
    assign sc_resp_success = resp_success_q;
    assign llbit_o         = valid_vec;

endmodule

// File: doc/llbit_resv_table.md
Name: llbit_resv_table

Overview:
- Multi-thread LL/SC reservation tracker for the LoongArch memory stage.
- Holds one reservation per hardware thread: a valid bit, a cache-line address tag and an optional timeout counter.
- Reservations are set by LL.W/LL.D and consumed by SC.W/SC.D.
- Reservations are cleared by flush (exception/ERTN), by a matching store snoop, or by timeout.
- Registered SC verdicts are returned to the writeback path.

Parameters:
- NUM_THREADS, 2, number of hardware threads (reservations).
- ADDR_WIDTH, 32, physical address width.
- LINE_OFFSET, 4, low address bits ignored for reservation granule (16-byte line).
- TIMEOUT_CYCLES, 1023, cycles a reservation survives without SC; 0 disables timeout.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low (asserted at 0).
- ll_valid  in  1  LL executing this cycle.
- ll_tid  in  $clog2(NUM_THREADS) (min 1)  issuing thread.
- ll_addr  in  ADDR_WIDTH  LL physical address.
- sc_valid  in  1  SC executing this cycle.
- sc_tid  in  same as ll_tid  issuing thread.
- sc_addr  in  ADDR_WIDTH  SC physical address.
- snoop_valid  in  1  committed store or external invalidate observed.
- snoop_addr  in  ADDR_WIDTH  store/invalidate physical address.
- flush  in  NUM_THREADS  per-thread clear mask (exception, ERTN, LLBCTL.WCLLB).
- sc_resp_valid  out  1  SC verdict valid.
- sc_resp_success  out  1  1 = SC may write memory and returns 1.
- llbit_o  out  NUM_THREADS  current valid bits (CSR LLBCTL.ROLLB readout).

Behaviour:
- Reset (rst=0, asynchronous):
  - all valid bits, tags and counters go to 0.
  - sc_resp_valid=0, sc_resp_success=0, llbit_o=0.
  - Reset mid-operation discards a pending verdict.
- Tag: addr[ADDR_WIDTH-1:LINE_OFFSET]. A match compares tags only.
- Per-thread state is IDLE (valid=0) or HELD (valid=1).
- Next-state priority per thread t, highest first:
  1. flush[t]=1 -> IDLE.
  2. ll_valid and ll_tid==t -> HELD, tag<=tag(ll_addr), counter<=TIMEOUT_CYCLES. This applies even when already HELD (re-arm).
  3. sc_valid and sc_tid==t -> IDLE. SC always consumes the reservation, success or not.
  4. snoop_valid and HELD and tag match -> IDLE. Snoop clears every matching thread, including the storing thread.
  5. TIMEOUT_CYCLES!=0, HELD, counter==1 -> IDLE. Otherwise a HELD counter decrements by 1 and saturates at 0, with no wrap-around.
- SC verdict latency is 1 cycle:
  - sc_resp_valid <= sc_valid.
  - sc_resp_success <= sc_valid & valid[sc_tid] & tag match(sc_addr) & ~flush[sc_tid] & ~(snoop_valid & snoop tag == tag[sc_tid]).
  - The verdict uses pre-edge state. A same-cycle flush or snoop hit to the reservation kills success.
- Same-cycle LL and SC on the same thread:
  - the SC verdict uses old state;
  - LL wins, so the thread ends HELD with the new tag.
- LL and SC on different threads in the same cycle are independent.
- A snoop in the same cycle as an LL to the same line does not clear the new reservation (LL priority).
- An SC with sc_tid >= NUM_THREADS, or to a thread in IDLE, gives success=0.
- llbit_o reflects registered state; it updates the cycle after the causing event.
- The counter width is $clog2(TIMEOUT_CYCLES+1) with a minimum of 1. When TIMEOUT_CYCLES=0 no counter logic is generated.

Decomposition:
- Shared package cpu_pkg (or defines.v constants):
  - LLBIT_LINE_OFFSET;
  - the thread-id width macro;
  - a resv_entry_t bundle {valid, tag, cnt}.
- One sub-module, llbit_resv_entry, holds the single-thread state machine plus counter and is instantiated NUM_THREADS times via generate.
- The top level does tid decode, the verdict mux and the response register.

Test Plan:
- Basic pair: ll t0 addr 0x1000_0040, wait 3 cycles, sc t0 addr 0x1000_0048 -> next cycle sc_resp_valid=1, success=1; llbit_o[0]=0 afterwards.
- Snoop kill: ll t1 0x2000_0000; snoop 0x2000_000C two cycles later; sc t1 0x2000_0000 -> success=0. Repeat with snoop 0x2000_0010 (other line) -> success=1.
- Flush vs same-cycle SC: ll t0 0x40; then in one cycle sc t0 0x40 with flush=2'b01 -> success=0, llbit_o[0]=0. Flush 2'b10 alone leaves llbit_o[0]=1.
- Timeout with TIMEOUT_CYCLES=8: ll t0 at cycle 0 -> llbit_o[0] falls to 0 after exactly 8 cycles; an sc at cycle 10 -> success=0. A re-arming ll at cycle 5 delays the clear until cycle 13.
- Same-cycle LL+SC on t0 with prior reservation 0x80: ll 0x100 and sc 0x80 together -> success=1, llbit_o[0]=1 with tag 0x100. A subsequent sc 0x100 -> success=1.
- Async reset: drop rst mid-cycle while sc_valid=1 -> sc_resp_valid and llbit_o go to 0 immediately without a clock edge, and stay 0 after release until the next ll.
